// File: rtl/dbf_line_seq_pkg.sv
// Shared types and sizing helpers for the per-line DBF sequencer.
package dbf_line_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_GUARD,
        ST_RX,
        ST_DONE
    } seq_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned lut_depth(input int unsigned lines, input int unsigned zones);
        return lines * zones;
    endfunction

endpackage

// File: rtl/dbf_line_seq_zone_cnt.sv
// Sample/zone counter pair for the receive window of one scan line.
module dbf_zone_cnt
    import dbf_line_seq_pkg::*;
#(
    parameter int unsigned ZONE_LEN  = 32,
    parameter int unsigned NUM_ZONES = 16,
    parameter int unsigned ZW        = cnt_width(NUM_ZONES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [ZW-1:0] zone,
    output logic          zone_wrap,
    output logic          last
);

    localparam int unsigned SW = cnt_width(ZONE_LEN);
    localparam logic [SW-1:0] S_MAX = SW'(ZONE_LEN - 1);
    localparam logic [ZW-1:0] Z_MAX = ZW'(NUM_ZONES - 1);

    logic [SW-1:0] sample;
    logic          sample_end;

    assign sample_end = (sample == S_MAX);
    assign last       = sample_end && (zone == Z_MAX);
    assign zone_wrap  = en && sample_end && (zone != Z_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sample <= '0;
            zone   <= '0;
        end else if (en) begin
            if (sample_end) begin
                sample <= '0;
                zone   <= (zone == Z_MAX) ? '0 : zone + 1'b1;
            end else begin
                sample <= sample + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbf_line_seq.sv
// Scan-line sequencer: TX window, guard gap, RX window with per-zone delay-LUT addressing.
module dbf_line_seq
    import dbf_line_seq_pkg::*;
#(
    parameter int unsigned ADDR_WD   = 10,
    parameter int unsigned TX_LEN    = 64,
    parameter int unsigned GUARD_LEN = 16,
    parameter int unsigned ZONE_LEN  = 32,
    parameter int unsigned NUM_ZONES = 16,
    parameter int unsigned NUM_LINES = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              line_trig,
    input  logic                              abort,
    output logic                              tx_en,
    output logic                              start,
    output logic [ADDR_WD-1:0]                dbf_lut_addr,
    output logic                              dbf_lut_we,
    output logic [cnt_width(NUM_LINES)-1:0]   line_idx,
    output logic                              busy,
    output logic                              line_done,
    output logic                              overrun
);

    localparam int unsigned LW = cnt_width(NUM_LINES);
    localparam int unsigned ZW = cnt_width(NUM_ZONES);
    localparam int unsigned CW = cnt_width((TX_LEN > GUARD_LEN) ? TX_LEN : GUARD_LEN);
    localparam logic [CW-1:0] TX_LOAD    = CW'(TX_LEN - 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'((GUARD_LEN > 0) ? GUARD_LEN - 1 : 0);

    if (lut_depth(NUM_LINES, NUM_ZONES) > (2 ** ADDR_WD)) begin : g_bad_addr_wd
        $error("dbf_line_seq: ADDR_WD too narrow for NUM_LINES*NUM_ZONES");
    end

    seq_state_t           state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [LW-1:0]        line_idx_d;
    logic [ZW-1:0]        zone;
    logic                 zone_wrap, zone_last;
    logic                 we_d;
    logic [ADDR_WD-1:0]   addr_d;

    dbf_zone_cnt #(
        .ZONE_LEN  (ZONE_LEN),
        .NUM_ZONES (NUM_ZONES),
        .ZW        (ZW)
    ) u_zone_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state != ST_RX),
        .en        (state == ST_RX),
        .zone      (zone),
        .zone_wrap (zone_wrap),
        .last      (zone_last)
    );

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        line_idx_d = line_idx;
        unique case (state)
            ST_IDLE: begin
                if (line_trig) begin
                    state_d = ST_TX;
                    cnt_d   = TX_LOAD;
                end
            end
            ST_TX: begin
                if (cnt == '0) begin
                    state_d = (GUARD_LEN > 0) ? ST_GUARD : ST_RX;
                    cnt_d   = GUARD_LOAD;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt == '0) state_d = ST_RX;
                else           cnt_d   = cnt - 1'b1;
            end
            ST_RX: begin
                if (zone_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                line_idx_d = (line_idx == LW'(NUM_LINES - 1)) ? '0 : line_idx + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides every transition and leaves line_idx alone so the line is re-fired.
        if (abort) begin
            state_d    = ST_IDLE;
            line_idx_d = line_idx;
        end
    end

    // Outputs are registered from next-state, so the address lands with its strobe.
    always_comb begin
        we_d   = (state_d == ST_RX) && ((state != ST_RX) || zone_wrap);
        addr_d = ADDR_WD'(line_idx) * ADDR_WD'(NUM_ZONES)
               + ((state == ST_RX) ? ADDR_WD'(zone) + ADDR_WD'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            line_idx     <= '0;
            tx_en        <= 1'b0;
            start        <= 1'b0;
            busy         <= 1'b0;
            line_done    <= 1'b0;
            dbf_lut_we   <= 1'b0;
            dbf_lut_addr <= '0;
            overrun      <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            line_idx   <= line_idx_d;
            tx_en      <= (state_d == ST_TX);
            start      <= (state_d == ST_RX);
            busy       <= (state_d != ST_IDLE);
            line_done  <= (state_d == ST_DONE);
            dbf_lut_we <= we_d;
            if (we_d) dbf_lut_addr <= addr_d;
            if (line_trig && (state != ST_IDLE)) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dbf_line_seq.sv
// Directed self-checking bench for dbf_line_seq (guarded and zero-guard builds).
module tb_dbf_line_seq;

    logic       clk = 1'b0;
    logic       rst_n, line_trig, abort, line_trig0, abort0;
    logic       tx_en, start, dbf_lut_we, busy, line_done, overrun;
    logic       tx_en0, start0, dbf_lut_we0, busy0, line_done0, overrun0;
    logic [3:0] dbf_lut_addr, dbf_lut_addr0;
    logic [1:0] line_idx, line_idx0;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    dbf_line_seq #(
        .ADDR_WD(4), .TX_LEN(4), .GUARD_LEN(2), .ZONE_LEN(3), .NUM_ZONES(2), .NUM_LINES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .line_trig(line_trig), .abort(abort),
        .tx_en(tx_en), .start(start), .dbf_lut_addr(dbf_lut_addr), .dbf_lut_we(dbf_lut_we),
        .line_idx(line_idx), .busy(busy), .line_done(line_done), .overrun(overrun)
    );

    dbf_line_seq #(
        .ADDR_WD(4), .TX_LEN(4), .GUARD_LEN(0), .ZONE_LEN(3), .NUM_ZONES(2), .NUM_LINES(3)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .line_trig(line_trig0), .abort(abort0),
        .tx_en(tx_en0), .start(start0), .dbf_lut_addr(dbf_lut_addr0), .dbf_lut_we(dbf_lut_we0),
        .line_idx(line_idx0), .busy(busy0), .line_done(line_done0), .overrun(overrun0)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; line_trig = 1'b0; abort = 1'b0; line_trig0 = 1'b0; abort0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; line_trig = 1'b1; abort = 1'b0; line_trig0 = 1'b1; abort0 = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({tx_en, start, dbf_lut_we, busy, line_done, overrun, dbf_lut_addr, line_idx} !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {tx_en, start, dbf_lut_we, busy, line_done, overrun, dbf_lut_addr, line_idx});
        end
        tests++;
        if ({tx_en0, start0, busy0, overrun0, line_idx0} !== 6'd0) begin
            fails++;
            $display("FAIL reset_outputs_g0: got %b expected all zero",
                     {tx_en0, start0, busy0, overrun0, line_idx0});
        end
        line_trig = 1'b0; line_trig0 = 1'b0; rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests++;
            if ({tx_en, start, busy, dbf_lut_we} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_idle c=%0d: got %b expected 0000", c, {tx_en, start, busy, dbf_lut_we});
            end
        end
    endtask

    task automatic test_single_line();
        logic [4:0] exp_ctl;
        apply_reset();
        @(negedge clk);
        line_trig = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            line_trig = 1'b0;
            exp_ctl = {(c >= 1 && c <= 4), (c >= 7 && c <= 12), (c == 7 || c == 10),
                       (c >= 1 && c <= 13), (c == 13)};
            tests++;
            if ({tx_en, start, dbf_lut_we, busy, line_done} !== exp_ctl) begin
                fails++;
                $display("FAIL single_ctl c=%0d: got %b expected %b (tx,start,we,busy,done)",
                         c, {tx_en, start, dbf_lut_we, busy, line_done}, exp_ctl);
            end
            if (c == 7 || c == 10) begin
                tests++;
                if (dbf_lut_addr !== ((c == 7) ? 4'd0 : 4'd1)) begin
                    fails++;
                    $display("FAIL single_addr c=%0d: got %0d expected %0d",
                             c, dbf_lut_addr, (c == 7) ? 0 : 1);
                end
            end
            tests++;
            if (line_idx !== ((c >= 14) ? 2'd1 : 2'd0)) begin
                fails++;
                $display("FAIL single_idx c=%0d: got %0d expected %0d", c, line_idx, (c >= 14) ? 1 : 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_a0 [4] = '{4'd0, 4'd2, 4'd4, 4'd0};
        logic [1:0] exp_idx[4] = '{2'd1, 2'd2, 2'd0, 2'd1};
        apply_reset();
        for (int l = 0; l < 4; l++) begin
            @(negedge clk);
            line_trig = 1'b1;
            for (int c = 1; c <= 14; c++) begin
                @(negedge clk);
                line_trig = 1'b0;
                if (c == 7 || c == 10) begin
                    tests++;
                    if (dbf_lut_we !== 1'b1 || dbf_lut_addr !== exp_a0[l] + ((c == 10) ? 4'd1 : 4'd0)) begin
                        fails++;
                        $display("FAIL b2b_strobe line=%0d c=%0d: got we=%b addr=%0d expected we=1 addr=%0d",
                                 l, c, dbf_lut_we, dbf_lut_addr, exp_a0[l] + ((c == 10) ? 4'd1 : 4'd0));
                    end
                end
                if (c == 13) begin
                    tests++;
                    if (line_done !== 1'b1) begin
                        fails++;
                        $display("FAIL b2b_done line=%0d: got %b expected 1", l, line_done);
                    end
                end
            end
            tests++;
            if (line_idx !== exp_idx[l]) begin
                fails++;
                $display("FAIL b2b_idx line=%0d: got %0d expected %0d", l, line_idx, exp_idx[l]);
            end
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        @(negedge clk);
        line_trig = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            line_trig = (c == 8);
            tests++;
            if (overrun !== ((c >= 9) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL overrun_flag c=%0d: got %b expected %b", c, overrun, (c >= 9));
            end
            if (c == 13 || c == 16) begin
                tests++;
                if ({line_done, busy} !== ((c == 13) ? 2'b11 : 2'b00)) begin
                    fails++;
                    $display("FAIL overrun_line c=%0d: got done,busy=%b expected %b",
                             c, {line_done, busy}, (c == 13) ? 2'b11 : 2'b00);
                end
            end
        end
    endtask

    task automatic test_abort();
        apply_reset();
        @(negedge clk);
        line_trig = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            line_trig = 1'b0;
            abort = (c == 9);
            if (c >= 10) begin
                tests++;
                if ({tx_en, start, dbf_lut_we, busy, line_done, overrun, dbf_lut_addr, line_idx} !== 12'd0) begin
                    fails++;
                    $display("FAIL abort_quiet c=%0d: got %b expected all zero", c,
                             {tx_en, start, dbf_lut_we, busy, line_done, overrun, dbf_lut_addr, line_idx});
                end
            end
        end
        abort = 1'b0;
        line_trig = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            line_trig = 1'b0;
            if (c == 7 || c == 10) begin
                tests++;
                if (dbf_lut_we !== 1'b1 || dbf_lut_addr !== ((c == 7) ? 4'd0 : 4'd1)) begin
                    fails++;
                    $display("FAIL abort_refire c=%0d: got we=%b addr=%0d expected we=1 addr=%0d",
                             c, dbf_lut_we, dbf_lut_addr, (c == 7) ? 0 : 1);
                end
            end
        end
        tests++;
        if (line_idx !== 2'd1) begin
            fails++;
            $display("FAIL abort_refire_idx: got %0d expected 1", line_idx);
        end
    endtask

    task automatic test_no_guard();
        logic [4:0] exp_ctl;
        apply_reset();
        @(negedge clk);
        line_trig0 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            line_trig0 = 1'b0;
            exp_ctl = {(c >= 1 && c <= 4), (c >= 5 && c <= 10), (c == 5 || c == 8),
                       (c >= 1 && c <= 11), (c == 11)};
            tests++;
            if ({tx_en0, start0, dbf_lut_we0, busy0, line_done0} !== exp_ctl) begin
                fails++;
                $display("FAIL noguard_ctl c=%0d: got %b expected %b (tx,start,we,busy,done)",
                         c, {tx_en0, start0, dbf_lut_we0, busy0, line_done0}, exp_ctl);
            end
            if (c == 5 || c == 8) begin
                tests++;
                if (dbf_lut_addr0 !== ((c == 5) ? 4'd0 : 4'd1)) begin
                    fails++;
                    $display("FAIL noguard_addr c=%0d: got %0d expected %0d",
                             c, dbf_lut_addr0, (c == 5) ? 0 : 1);
                end
            end
        end
        line_trig0 = 1'b1;
        abort0 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            line_trig0 = 1'b0;
            abort0 = 1'b0;
            tests++;
            if ({tx_en0, start0, busy0, overrun0, line_idx0} !== 6'b0000_01) begin
                fails++;
                $display("FAIL noguard_abort_trig c=%0d: got %b expected 000001",
                         c, {tx_en0, start0, busy0, overrun0, line_idx0});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; line_trig = 1'b0; abort = 1'b0; line_trig0 = 1'b0; abort0 = 1'b0;
        test_reset();
        test_single_line();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_no_guard();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
